// File: rtl/z_mult_pkg.sv
// Shared constants and the fixed-point round/saturate helper for the complex multiplier.
package z_mult_pkg;

    localparam int unsigned W_DEF    = 16;
    localparam int unsigned FRAC_DEF = 14;
    localparam int unsigned Q_ONE    = 2 ** FRAC_DEF;
    localparam int unsigned PIPE_LAT = 3;

    typedef struct packed {
        logic               ovf;
        logic signed [63:0] result;
    } fx_res_t;

    // Shifts value down by frac bits (optionally round-half-up), then range-checks against w bits.
    // With sat clear the caller keeps the low w bits of result.
    function automatic fx_res_t fx_round_sat(input logic signed [63:0] value,
                                             input logic               round,
                                             input logic               sat,
                                             input int unsigned        w,
                                             input int unsigned        frac);
        fx_res_t            res;
        logic signed [63:0] v;
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        v = value;
        if (round && (frac > 0)) begin
            v = v + (64'sd1 <<< (frac - 1));
        end
        v = v >>> frac;
        max_v = (64'sd1 <<< (w - 1)) - 64'sd1;
        min_v = -(64'sd1 <<< (w - 1));
        res.ovf    = (v > max_v) || (v < min_v);
        res.result = v;
        if (res.ovf && sat) begin
            res.result = (v > max_v) ? max_v : min_v;
        end
        return res;
    endfunction

endpackage

// File: rtl/z_mult_round_sat.sv
// Combinational round/shift and saturate-or-wrap of one 2W+2-bit accumulator component.
module z_mult_round_sat
    import z_mult_pkg::*;
#(
    parameter int unsigned W     = 16,
    parameter int unsigned FRAC  = 14,
    parameter bit          ROUND = 1'b1,
    parameter bit          SAT   = 1'b1
) (
    input  logic signed [2*W+1:0] value_i,
    output logic signed [W-1:0]   result_o,
    output logic                  ovf_o
);

    fx_res_t res;
    logic    unused_hi;

    always_comb begin
        res = fx_round_sat(64'(value_i), ROUND, SAT, W, FRAC);
    end

    assign result_o  = res.result[W-1:0];
    assign ovf_o     = res.ovf;
    // Upper bits are only a sign extension once the range check has run.
    assign unused_hi = ^res.result[63:W];

endmodule

// File: rtl/z_multiplier_pipe.sv
// Three-stage pipelined complex multiplier with optional conj(B), round/saturate and
// valid/ready back-pressure; every stage shares one advance enable.
module z_multiplier_pipe
    import z_mult_pkg::*;
#(
    parameter int unsigned W     = W_DEF,
    parameter int unsigned FRAC  = FRAC_DEF,
    parameter bit          ROUND = 1'b1,
    parameter bit          SAT   = 1'b1,
    parameter int unsigned CNT_W = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic                conj_b_i,
    input  logic signed [W-1:0] ar_i,
    input  logic signed [W-1:0] ai_i,
    input  logic signed [W-1:0] br_i,
    input  logic signed [W-1:0] bi_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic signed [W-1:0] rout_o,
    output logic signed [W-1:0] iout_o,
    output logic                ovf_o,
    output logic [CNT_W-1:0]    sat_cnt_o,
    input  logic                clr_cnt_i
);

    localparam int unsigned PW = 2 * W + 1;
    localparam int unsigned SW = 2 * W + 2;

    logic                 advance;
    logic                 accept;
    logic                 v1_q;
    logic                 v2_q;
    logic                 out_valid_q;
    logic signed [W-1:0]  ar_q, ai_q, br_q;
    logic signed [W:0]    bi_d, bi_q;
    logic signed [PW-1:0] p_rr_d, p_ii_d, p_ri_d, p_ir_d;
    logic signed [PW-1:0] p_rr_q, p_ii_q, p_ri_q, p_ir_q;
    logic signed [SW-1:0] re_d, im_d;
    logic signed [W-1:0]  re_rs, im_rs;
    logic                 re_ovf, im_ovf;
    logic signed [W-1:0]  rout_q, iout_q;
    logic                 ovf_q;
    logic [CNT_W-1:0]     cnt_d, cnt_q;

    assign advance    = out_ready_i | ~out_valid_q;
    assign in_ready_o = advance;
    assign accept     = in_valid_i & advance;

    // Negate at W+1 bits so conj of the most negative Bi stays representable.
    always_comb begin
        bi_d = (W + 1)'(bi_i);
        if (conj_b_i) begin
            bi_d = -bi_d;
        end
    end

    always_comb begin
        p_rr_d = PW'(ar_q) * PW'(br_q);
        p_ii_d = PW'(ai_q) * PW'(bi_q);
        p_ri_d = PW'(ar_q) * PW'(bi_q);
        p_ir_d = PW'(ai_q) * PW'(br_q);
        re_d   = SW'(p_rr_q) - SW'(p_ii_q);
        im_d   = SW'(p_ri_q) + SW'(p_ir_q);
    end

    z_mult_round_sat #(
        .W     (W),
        .FRAC  (FRAC),
        .ROUND (ROUND),
        .SAT   (SAT)
    ) u_rs_re (
        .value_i  (re_d),
        .result_o (re_rs),
        .ovf_o    (re_ovf)
    );

    z_mult_round_sat #(
        .W     (W),
        .FRAC  (FRAC),
        .ROUND (ROUND),
        .SAT   (SAT)
    ) u_rs_im (
        .value_i  (im_d),
        .result_o (im_rs),
        .ovf_o    (im_ovf)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            out_valid_q <= 1'b0;
            ar_q        <= '0;
            ai_q        <= '0;
            br_q        <= '0;
            bi_q        <= '0;
            p_rr_q      <= '0;
            p_ii_q      <= '0;
            p_ri_q      <= '0;
            p_ir_q      <= '0;
            rout_q      <= '0;
            iout_q      <= '0;
            ovf_q       <= 1'b0;
        end else if (advance) begin
            v1_q        <= accept;
            v2_q        <= v1_q;
            out_valid_q <= v2_q;
            if (accept) begin
                ar_q <= ar_i;
                ai_q <= ai_i;
                br_q <= br_i;
                bi_q <= bi_d;
            end
            if (v1_q) begin
                p_rr_q <= p_rr_d;
                p_ii_q <= p_ii_d;
                p_ri_q <= p_ri_d;
                p_ir_q <= p_ir_d;
            end
            if (v2_q) begin
                rout_q <= re_rs;
                iout_q <= im_rs;
                ovf_q  <= re_ovf | im_ovf;
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (clr_cnt_i) begin
            cnt_d = '0;
        end else if (out_valid_q && out_ready_i && ovf_q && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign rout_o      = rout_q;
    assign iout_o      = iout_q;
    assign ovf_o       = ovf_q;
    assign sat_cnt_o   = cnt_q;

endmodule

// File: tb/tb_z_multiplier_pipe.sv
// Scoreboard bench: three multiplier variants (round+sat, trunc+sat, round+wrap) run in lockstep.
module tb_z_multiplier_pipe;

    localparam int W    = 16;
    localparam int FRAC = 14;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                in_valid, conj_b, out_ready, clr_cnt;
    logic signed [W-1:0] ar, ai, br, bi;
    logic                in_ready, in_ready_tr, in_ready_wr;
    logic                out_valid, out_valid_tr, out_valid_wr;
    logic signed [W-1:0] rout, iout, rout_tr, iout_tr, rout_wr, iout_wr;
    logic                ovf, ovf_tr, ovf_wr;
    logic [15:0]         sat_cnt, sat_cnt_tr, sat_cnt_wr;

    int errors;
    int checks;
    int exp_cnt[3];

    typedef struct {
        int r;
        int i;
        bit o;
    } res_t;
    typedef struct {
        res_t v[3];
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    z_multiplier_pipe #(.W(W), .FRAC(FRAC), .ROUND(1'b1), .SAT(1'b1), .CNT_W(16)) dut (
        .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .conj_b_i(conj_b), .ar_i(ar), .ai_i(ai), .br_i(br), .bi_i(bi),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .rout_o(rout), .iout_o(iout),
        .ovf_o(ovf), .sat_cnt_o(sat_cnt), .clr_cnt_i(clr_cnt)
    );

    z_multiplier_pipe #(.W(W), .FRAC(FRAC), .ROUND(1'b0), .SAT(1'b1), .CNT_W(16)) dut_tr (
        .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready_tr),
        .conj_b_i(conj_b), .ar_i(ar), .ai_i(ai), .br_i(br), .bi_i(bi),
        .out_valid_o(out_valid_tr), .out_ready_i(out_ready), .rout_o(rout_tr),
        .iout_o(iout_tr), .ovf_o(ovf_tr), .sat_cnt_o(sat_cnt_tr), .clr_cnt_i(clr_cnt)
    );

    z_multiplier_pipe #(.W(W), .FRAC(FRAC), .ROUND(1'b1), .SAT(1'b0), .CNT_W(16)) dut_wr (
        .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready_wr),
        .conj_b_i(conj_b), .ar_i(ar), .ai_i(ai), .br_i(br), .bi_i(bi),
        .out_valid_o(out_valid_wr), .out_ready_i(out_ready), .rout_o(rout_wr),
        .iout_o(iout_wr), .ovf_o(ovf_wr), .sat_cnt_o(sat_cnt_wr), .clr_cnt_i(clr_cnt)
    );

    function automatic longint fx(input longint v, input bit rnd, input bit sat, output bit o);
        longint s;
        s = rnd ? v + (longint'(1) <<< (FRAC - 1)) : v;
        s = s >>> FRAC;
        o = (s > 32767) || (s < -32768);
        if (!o) return s;
        if (sat) return (s > 0) ? 32767 : -32768;
        return longint'(shortint'(s));
    endfunction

    function automatic res_t model(input int a_r, input int a_i, input int b_r, input int b_i,
                                   input bit cj, input bit rnd, input bit sat);
        longint bie, re, im;
        bit     o1, o2;
        res_t   x;
        bie = cj ? -longint'(b_i) : longint'(b_i);
        re  = longint'(a_r) * b_r - longint'(a_i) * bie;
        im  = longint'(a_r) * bie + longint'(a_i) * b_r;
        x.r = int'(fx(re, rnd, sat, o1));
        x.i = int'(fx(im, rnd, sat, o2));
        x.o = o1 | o2;
        return x;
    endfunction

    // Mid-cycle monitor: what is visible here is what the next rising edge will act on.
    always @(negedge clk) begin
        int          rr[3];
        int          ii[3];
        logic        oo[3];
        logic [15:0] cc[3];
        exp_t        e;
        exp_t        n;
        #2;
        if (rst_n === 1'b1) begin
            rr = '{int'(rout), int'(rout_tr), int'(rout_wr)};
            ii = '{int'(iout), int'(iout_tr), int'(iout_wr)};
            oo = '{ovf, ovf_tr, ovf_wr};
            cc = '{sat_cnt, sat_cnt_tr, sat_cnt_wr};
            checks++;
            if (out_valid_tr !== out_valid || out_valid_wr !== out_valid ||
                in_ready_tr !== in_ready || in_ready_wr !== in_ready) begin
                errors++;
                $display("FAIL lockstep: got valid=%b/%b/%b ready=%b/%b/%b, want all equal",
                         out_valid, out_valid_tr, out_valid_wr, in_ready, in_ready_tr,
                         in_ready_wr);
            end
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (cc[k] !== 16'(exp_cnt[k])) begin
                    errors++;
                    $display("FAIL sat_cnt[%0d]: got %0d, want %0d", k, cc[k], exp_cnt[k]);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output: got r=%0d i=%0d, want no output",
                             rr[0], ii[0]);
                end else begin
                    e = sb.pop_front();
                    for (int k = 0; k < 3; k++) begin
                        checks++;
                        if (rr[k] !== e.v[k].r || ii[k] !== e.v[k].i || oo[k] !== e.v[k].o) begin
                            errors++;
                            $display("FAIL result[%0d]: got r=%0d i=%0d ovf=%b, want r=%0d i=%0d ovf=%b",
                                     k, rr[k], ii[k], oo[k], e.v[k].r, e.v[k].i, e.v[k].o);
                        end
                        if (e.v[k].o && exp_cnt[k] < 65535) exp_cnt[k]++;
                    end
                end
            end
            if (clr_cnt) exp_cnt = '{0, 0, 0};
            if (in_valid && in_ready) begin
                n.v[0] = model(int'(ar), int'(ai), int'(br), int'(bi), conj_b, 1'b1, 1'b1);
                n.v[1] = model(int'(ar), int'(ai), int'(br), int'(bi), conj_b, 1'b0, 1'b1);
                n.v[2] = model(int'(ar), int'(ai), int'(br), int'(bi), conj_b, 1'b1, 1'b0);
                sb.push_back(n);
            end
        end
    end

    // Drives one sample with out_ready low, so the result parks at the output for inspection.
    task automatic send_one(input int a_r, input int a_i, input int b_r, input int b_i,
                            input bit cj, output int lat);
        @(negedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        ar = a_r[W-1:0]; ai = a_i[W-1:0]; br = b_r[W-1:0]; bi = b_i[W-1:0];
        conj_b = cj;
        lat = -1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk); #1;
            in_valid = 1'b0;
            if (out_valid) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic release_out();
        @(negedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || rout !== '0 || iout !== '0 || ovf !== 1'b0 || sat_cnt !== '0) begin
            errors++;
            $display("FAIL reset_state: got v=%b r=%0d i=%0d ovf=%b cnt=%0d, want all 0",
                     out_valid, rout, iout, ovf, sat_cnt);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b, want 1", in_ready);
        end
        rst_n = 1'b1;
        @(negedge clk); #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL after_reset: got ready=%b valid=%b, want 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_latency();
        int lat;
        send_one(8192, 0, 0, -16384, 1'b0, lat);
        checks++;
        if (lat !== 3) begin
            errors++;
            $display("FAIL latency: got %0d, want 3", lat);
        end
        checks++;
        if (int'(rout) !== 0 || int'(iout) !== -8192 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL half_times_minus_j: got r=%0d i=%0d ovf=%b, want 0 -8192 0",
                     rout, iout, ovf);
        end
        release_out();
    endtask

    task automatic test_rounding();
        int lat;
        send_one(14746, 14746, 14746, 14746, 1'b0, lat);
        checks++;
        if (lat < 0 || int'(rout) !== 0 || int'(iout) !== 26544 || int'(iout_tr) !== 26543) begin
            errors++;
            $display("FAIL round_0p9sq: got r=%0d i=%0d i_trunc=%0d, want 0 26544 26543",
                     rout, iout, iout_tr);
        end
        release_out();
        send_one(1, 0, -8192, 0, 1'b0, lat);
        checks++;
        if (lat < 0 || int'(rout) !== 0 || int'(rout_tr) !== -1) begin
            errors++;
            $display("FAIL round_neg_half: got r=%0d r_trunc=%0d, want 0 -1", rout, rout_tr);
        end
        release_out();
    endtask

    task automatic test_saturation();
        int lat;
        send_one(16384, 16384, 16384, 16384, 1'b0, lat);
        checks++;
        if (lat < 0 || int'(rout) !== 0 || int'(iout) !== 32767 || ovf !== 1'b1) begin
            errors++;
            $display("FAIL sat_pos: got r=%0d i=%0d ovf=%b, want 0 32767 1", rout, iout, ovf);
        end
        checks++;
        if (int'(iout_wr) !== -32768 || ovf_wr !== 1'b1) begin
            errors++;
            $display("FAIL wrap_pos: got i=%0d ovf=%b, want -32768 1", iout_wr, ovf_wr);
        end
        release_out();
        checks++;
        if (sat_cnt !== 16'd1) begin
            errors++;
            $display("FAIL sat_cnt_first: got %0d, want 1", sat_cnt);
        end
        send_one(-32768, 0, 0, -32768, 1'b1, lat);
        checks++;
        if (lat < 0 || int'(iout) !== -32768 || int'(iout_wr) !== 0 || ovf !== 1'b1) begin
            errors++;
            $display("FAIL sat_neg_conj: got i=%0d i_wrap=%0d ovf=%b, want -32768 0 1",
                     iout, iout_wr, ovf);
        end
        release_out();
    endtask

    task automatic test_conj();
        int lat;
        send_one(8192, 8192, 8192, 8192, 1'b1, lat);
        checks++;
        if (lat < 0 || int'(rout) !== 8192 || int'(iout) !== 0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL conj_mag: got r=%0d i=%0d ovf=%b, want 8192 0 0", rout, iout, ovf);
        end
        release_out();
        send_one(-16384, 0, -16384, 0, 1'b0, lat);
        checks++;
        if (lat < 0 || int'(rout) !== 16384 || int'(iout) !== 0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL neg_one_sq: got r=%0d i=%0d ovf=%b, want 16384 0 0", rout, iout, ovf);
        end
        release_out();
    endtask

    task automatic test_back_to_back();
        int                  sa[8][4];
        bit                  sc[8];
        logic signed [W-1:0] t;
        logic signed [W-1:0] pr, pi;
        logic                po;
        bit                  stalled;
        int                  n, c;
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 4; j++) begin
                t = W'($urandom);
                sa[i][j] = int'(t);
            end
            sc[i] = 1'($urandom);
        end
        n = 0; c = 0; stalled = 1'b0; pr = '0; pi = '0; po = 1'b0;
        while (n < 8 && c < 60) begin
            @(negedge clk); #1;
            out_ready = !(c >= 5 && c < 8);
            in_valid  = 1'b1;
            ar = sa[n][0][W-1:0]; ai = sa[n][1][W-1:0];
            br = sa[n][2][W-1:0]; bi = sa[n][3][W-1:0];
            conj_b = sc[n];
            #1;
            if (stalled) begin
                checks++;
                if (out_valid !== 1'b1 || rout !== pr || iout !== pi || ovf !== po) begin
                    errors++;
                    $display("FAIL hold: got v=%b r=%0d i=%0d, want 1 %0d %0d",
                             out_valid, rout, iout, pr, pi);
                end
            end
            checks++;
            if (in_ready !== !(out_valid && !out_ready)) begin
                errors++;
                $display("FAIL in_ready_stream: got %b at cycle %0d, want %b",
                         in_ready, c, !(out_valid && !out_ready));
            end
            stalled = out_valid && !out_ready;
            pr = rout; pi = iout; po = ovf;
            if (in_ready) n++;
            c++;
        end
        checks++;
        if (n != 8) begin
            errors++;
            $display("FAIL stream_accept: got %0d accepted, want 8", n);
        end
        @(negedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 20 && (sb.size() != 0 || out_valid); k++) @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d results missing, want 0", sb.size());
        end
    endtask

    task automatic test_reset_inflight();
        @(negedge clk); #1;
        out_ready = 1'b1; in_valid = 1'b1; conj_b = 1'b0;
        ar = 16384; ai = 16384; br = 16384; bi = 16384;
        @(negedge clk); #1;
        ar = 8192;
        @(negedge clk); #1;
        in_valid = 1'b0;
        rst_n    = 1'b0;
        sb.delete();
        exp_cnt = '{0, 0, 0};
        #1;
        checks++;
        if (out_valid !== 1'b0 || sat_cnt !== '0) begin
            errors++;
            $display("FAIL reset_inflight: got v=%b cnt=%0d, want 0 0", out_valid, sat_cnt);
        end
        @(negedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk); #1;
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL stale_after_reset: got valid=%b at cycle %0d, want 0",
                         out_valid, k);
            end
        end
    endtask

    task automatic test_clr_cnt();
        bit seen;
        @(negedge clk); #1;
        out_ready = 1'b1; in_valid = 1'b1; conj_b = 1'b0;
        ar = 16384; ai = 16384; br = 16384; bi = 16384;
        @(negedge clk); #1;
        @(negedge clk); #1;
        in_valid = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk); #1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL clr_timeout: got no output, want output within 10 cycles");
        end
        @(negedge clk); #1;
        checks++;
        if (sat_cnt !== 16'd1 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL clr_pre: got cnt=%0d v=%b, want 1 1", sat_cnt, out_valid);
        end
        clr_cnt = 1'b1;
        @(negedge clk); #1;
        clr_cnt = 1'b0;
        checks++;
        if (sat_cnt !== '0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL clr_wins: got cnt=%0d v=%b, want 0 0", sat_cnt, out_valid);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        errors = 0; checks = 0; exp_cnt = '{0, 0, 0};
        rst_n = 1'b0; in_valid = 1'b0; conj_b = 1'b0; out_ready = 1'b1; clr_cnt = 1'b0;
        ar = '0; ai = '0; br = '0; bi = '0;
        test_reset();
        test_latency();
        test_rounding();
        test_saturation();
        test_conj();
        test_back_to_back();
        test_reset_inflight();
        test_clr_cnt();
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
